p2s_tx_sequencer: RTL and testbench

- Controller that sequences the team's parallel-to-serial shifter, which loads a WIDTH-bit word and shifts out DATA_SIZE-bit chunks MSB-first.
- Accepts words from an upstream valid/ready source and drives the shifter's load/en strobes.
- Presents each chunk to a downstream byte sink (UART TX, SPI byte engine) with a valid/ready handshake.
- Supports per-word length, a programmable inter-byte gap, abort, and a completed-word counter.

---
 rtl/p2s_tx_sequencer_pkg.sv | 26 ++
 rtl/p2s_gap_timer.sv | 34 +++
 rtl/p2s_tx_sequencer.sv | 120 ++++++++++++
 tb/tb_p2s_tx_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_tx_sequencer_pkg.sv
// rtl/p2s_tx_sequencer_pkg.sv - shared types and helpers for the p2s transmit sequencer
//
// Purpose : FSM state encoding, effective word-length mapping and the
//           length-field width derivation used by p2s_tx_sequencer.
// Contents: state_t     IDLE / SEND / GAP
//           len_width() bits needed to hold 0..bytes
//           eff_len()   maps a requested chunk count onto 1..bytes
package p2s_tx_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One extra bit so the full count BYTES itself is representable.
  function automatic int len_width(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  // A length of zero, or one larger than the word holds, means "whole word".
  function automatic int eff_len(input int len, input int bytes);
    return ((len == 0) || (len > bytes)) ? bytes : len;
  endfunction

endpackage

// File: rtl/p2s_gap_timer.sv
// rtl/p2s_gap_timer.sv - loadable down-counter with zero flag for inter-byte gaps
//
// Purpose : Holds the remaining idle cycles of an inter-byte gap.
// Ports   : clk, rst       clock, synchronous active-high reset
//           load_i         load load_val_i (wins over dec_i)
//           load_val_i     value to load
//           dec_i          decrement by one, saturating at zero
//           zero_o         counter is zero
module p2s_gap_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/p2s_tx_sequencer.sv
// rtl/p2s_tx_sequencer.sv - sequences a parallel-to-serial shifter toward a byte sink
//
// Purpose : Accepts words from an upstream valid/ready source, strobes the
//           shifter's load/en, and offers each DATA_SIZE-bit chunk to a
//           downstream sink with a valid/ready handshake.
// Ports   : clk, rst       clock, synchronous active-high reset
//           word_valid     upstream word available
//           word_len       chunks to send (0 or >BYTES means BYTES)
//           word_ready     controller can accept a word
//           abort          drop the current word, return to IDLE
//           p2s_load       shifter load strobe
//           p2s_en         shifter shift strobe
//           byte_valid     shifter Q holds a chunk for the sink
//           byte_ready     sink accepts the chunk
//           busy           controller is not IDLE
//           word_count     completed (non-aborted) words, wrapping
module p2s_tx_sequencer
  import p2s_tx_sequencer_pkg::*;
#(
  parameter  int DATA_SIZE  = 8,
  parameter  int WIDTH      = 32,
  parameter  int GAP_CYCLES = 0,
  parameter  int CNT_WIDTH  = 16,
  localparam int BYTES      = WIDTH / DATA_SIZE,
  localparam int LEN_W      = len_width(BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 word_valid,
  input  logic [LEN_W-1:0]     word_len,
  output logic                 word_ready,
  input  logic                 abort,
  output logic                 p2s_load,
  output logic                 p2s_en,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count
);

  state_t                 state_q;
  logic [LEN_W-1:0]       bytes_left_q;
  logic [CNT_WIDTH-1:0]   word_count_q;
  logic                   gap_zero;
  logic                   last_byte;

  // Strobes are combinational on the registered state so the load happens in
  // the accepting cycle and the shift in the accepting cycle of each chunk.
  // abort masks both handshakes in the cycle it is seen.
  assign word_ready = (state_q == IDLE) && !abort;
  assign byte_valid = (state_q == SEND) && !abort;
  assign p2s_load   = word_ready && word_valid;
  assign p2s_en     = byte_valid && byte_ready;
  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;
  assign last_byte  = (bytes_left_q == LEN_W'(1));

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

      logic gap_load;
      logic gap_dec;

      // Armed on every accepted byte except the last one of the word.
      assign gap_load = p2s_en && !last_byte;
      assign gap_dec  = (state_q == GAP);

      p2s_gap_timer #(
        .W (GW)
      ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (GW'(GAP_CYCLES - 1)),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
      );
    end else begin : g_no_gap
      assign gap_zero = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bytes_left_q <= '0;
      word_count_q <= '0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (word_valid) begin
            bytes_left_q <= LEN_W'(eff_len(int'(word_len), BYTES));
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (byte_ready) begin
            bytes_left_q <= bytes_left_q - LEN_W'(1);
            if (last_byte) begin
              word_count_q <= word_count_q + CNT_WIDTH'(1);
              state_q      <= IDLE;
            end else if (GAP_CYCLES > 0) begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_zero) begin
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_tx_sequencer.sv
// tb/tb_p2s_tx_sequencer.sv - self-checking bench for p2s_tx_sequencer
module tb_p2s_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        word_valid = 1'b0;
  logic [2:0]  word_len = '0;
  logic        abort = 1'b0;
  logic        byte_ready = 1'b0;

  logic        wr0, ld0, en0, bv0, bs0;
  logic [3:0]  wc0;
  logic        wr3, ld3, en3, bv3, bs3;
  logic [15:0] wc3;

  int n_checks = 0;
  int n_errors = 0;
  bit use_gap = 1'b0;

  typedef struct {
    int n_en;
    int wc;
  } sb_t;
  sb_t exp_q[$];

  always #5 clk = ~clk;

  p2s_tx_sequencer #(.GAP_CYCLES(0), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_len(word_len),
    .word_ready(wr0), .abort(abort), .p2s_load(ld0), .p2s_en(en0),
    .byte_valid(bv0), .byte_ready(byte_ready), .busy(bs0), .word_count(wc0)
  );

  p2s_tx_sequencer #(.GAP_CYCLES(3), .CNT_WIDTH(16)) dut3 (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_len(word_len),
    .word_ready(wr3), .abort(abort), .p2s_load(ld3), .p2s_en(en3),
    .byte_valid(bv3), .byte_ready(byte_ready), .busy(bs3), .word_count(wc3)
  );

  logic        m_ready, m_load, m_en, m_valid, m_busy;
  logic [15:0] m_wc;
  assign m_ready = use_gap ? wr3 : wr0;
  assign m_load  = use_gap ? ld3 : ld0;
  assign m_en    = use_gap ? en3 : en0;
  assign m_valid = use_gap ? bv3 : bv0;
  assign m_busy  = use_gap ? bs3 : bs0;
  assign m_wc    = use_gap ? wc3 : {12'd0, wc0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the edge; outputs are sampled 1 time unit later.
  task automatic drive(input bit wv, input int wl, input bit br, input bit ab);
    @(posedge clk);
    #1;
    word_valid = wv;
    word_len   = 3'(wl);
    byte_ready = br;
    abort      = ab;
    #1;
  endtask

  task automatic expect_out(input string tag, input bit ld, input bit en,
                            input bit bv, input bit wr, input bit bs);
    chk({tag, ".p2s_load"},   m_load,  ld);
    chk({tag, ".p2s_en"},     m_en,    en);
    chk({tag, ".byte_valid"}, m_valid, bv);
    chk({tag, ".word_ready"}, m_ready, wr);
    chk({tag, ".busy"},       m_busy,  bs);
  endtask

  task automatic push_word(input int n_en, input int wc);
    sb_t e;
    e.n_en = n_en;
    e.wc   = wc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    expect_out(tag, 0, 0, 0, 1, 0);
    chk({tag, ".word_count"}, m_wc, 0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: counts shift strobes per word and, when the word
  // ends (busy falls), compares against the expectation pushed at load time.
  int en_cnt = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    chk("strobe_overlap", {31'd0, m_load & m_en}, 0);
    if (prev_busy && !m_busy) begin
      chk("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_en_count", en_cnt, e.n_en);
        chk("sb_word_count", m_wc, e.wc);
      end
    end
    if (m_load) en_cnt = 0;
    if (m_en) en_cnt++;
    prev_busy = m_busy;
  end

  initial begin
    do_reset("reset");

    // Full-width word (len 0 -> 4 chunks), sink always ready.
    drive(1, 0, 1, 0);
    expect_out("w4.c0", 1, 0, 0, 1, 0);
    push_word(4, 1);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0);
      expect_out($sformatf("w4.c%0d", i), 0, 1, 1, 0, 1);
    end
    drive(0, 0, 1, 0);
    expect_out("w4.c5", 0, 0, 0, 1, 0);
    chk("w4.word_count", m_wc, 1);

    // Two-chunk word with a 3-cycle sink stall; word_len changes are ignored.
    drive(1, 2, 0, 0);
    expect_out("stall.load", 1, 0, 0, 1, 0);
    push_word(2, 2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      expect_out($sformatf("stall.s%0d", i), 0, 0, 1, 0, 1);
    end
    drive(0, 1, 1, 0);
    expect_out("stall.b0", 0, 1, 1, 0, 1);
    drive(0, 1, 1, 0);
    expect_out("stall.b1", 0, 1, 1, 0, 1);
    drive(0, 0, 0, 0);
    expect_out("stall.done", 0, 0, 0, 1, 0);
    chk("stall.word_count", m_wc, 2);

    // Abort on the second chunk of a 4-chunk word while the sink is ready.
    drive(1, 4, 1, 0);
    expect_out("abort.load", 1, 0, 0, 1, 0);
    push_word(1, 2);
    drive(0, 0, 1, 0);
    expect_out("abort.b0", 0, 1, 1, 0, 1);
    drive(0, 0, 1, 1);
    expect_out("abort.hit", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0);
    expect_out("abort.idle", 0, 0, 0, 1, 0);
    chk("abort.word_count", m_wc, 2);
    // Abort while IDLE blocks acceptance.
    drive(1, 3, 1, 1);
    expect_out("abort.block", 0, 0, 0, 0, 0);
    drive(1, 3, 1, 0);
    expect_out("abort.next_load", 1, 0, 0, 1, 0);
    push_word(3, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      expect_out($sformatf("abort.next_b%0d", i), 0, 1, 1, 0, 1);
    end
    drive(0, 0, 0, 0);
    expect_out("abort.next_done", 0, 0, 0, 1, 0);
    chk("abort.next_word_count", m_wc, 3);

    // 17 one-chunk words back-to-back on a 4-bit counter: wraps to 1.
    do_reset("reset2");
    for (int w = 0; w < 17; w++) begin
      drive(1, 1, 1, 0);
      expect_out($sformatf("wrap.load%0d", w), 1, 0, 0, 1, 0);
      push_word(1, (w + 1) % 16);
      drive(1, 1, 1, 0);
      expect_out($sformatf("wrap.byte%0d", w), 0, 1, 1, 0, 1);
    end
    drive(0, 0, 0, 0);
    expect_out("wrap.done", 0, 0, 0, 1, 0);
    chk("wrap.word_count", m_wc, 1);

    // Switch to the GAP_CYCLES=3 instance.
    do_reset("reset3");
    use_gap = 1'b1;
    #1;
    drive(1, 4, 1, 0);
    expect_out("gap.c0", 1, 0, 0, 1, 0);
    push_word(4, 1);
    for (int c = 1; c <= 13; c++) begin
      bit acc;
      acc = (c % 4 == 1);
      drive(0, 0, 1, 0);
      expect_out($sformatf("gap.c%0d", c), 0, acc, acc, 0, 1);
    end
    drive(0, 0, 1, 0);
    expect_out("gap.c14", 0, 0, 0, 1, 0);
    chk("gap.word_count", m_wc, 1);

    // Reset in the middle of a gap.
    drive(1, 2, 1, 0);
    expect_out("rstgap.load", 1, 0, 0, 1, 0);
    push_word(1, 0);
    drive(0, 0, 1, 0);
    expect_out("rstgap.b0", 0, 1, 1, 0, 1);
    drive(0, 0, 1, 0);
    expect_out("rstgap.gap", 0, 0, 0, 0, 1);
    rst = 1'b1;
    drive(0, 0, 1, 0);
    rst = 1'b0;
    drive(0, 0, 1, 0);
    expect_out("rstgap.after", 0, 0, 0, 1, 0);
    chk("rstgap.word_count", m_wc, 0);

    drive(0, 0, 0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
